// File: rtl/tg_chain_master.sv
// Host-side master for the traffic-generator shift chains: buffers config words and
// streams them into the config chain head; shifts the stats chain and buffers its words.
module tg_chain_master #(
    parameter int CFG_WORDS  = 16,
    parameter int STAT_WORDS = 8,
    parameter int LOG_DEPTH  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] host_wdata,
    input  logic        host_wvalid,
    output logic        host_wready,
    output logic [15:0] host_rdata,
    output logic        host_rvalid,
    input  logic        host_rready,
    input  logic        start_config,
    input  logic        start_stats,
    output logic [15:0] config_out,
    output logic        config_out_valid,
    output logic        stats_shift,
    output logic [15:0] stats_out,
    input  logic [15:0] stats_in,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int DEPTH     = 1 << LOG_DEPTH;
    localparam int MAX_WORDS = (CFG_WORDS > STAT_WORDS) ? CFG_WORDS : STAT_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam int PTR_W     = LOG_DEPTH;
    localparam int FILL_W    = LOG_DEPTH + 1;

    if ((1 << LOG_DEPTH) < MAX_WORDS) begin : g_bad_depth
        $error("tg_chain_master: 2**LOG_DEPTH must be >= max(CFG_WORDS, STAT_WORDS)");
    end

    typedef enum logic [1:0] {IDLE, CFG, STAT, FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [15:0]        wmem_q [DEPTH];
    logic [PTR_W-1:0]   wwr_ptr_q, wwr_ptr_d, wrd_ptr_q, wrd_ptr_d;
    logic [FILL_W-1:0]  wcount_q, wcount_d;

    logic [15:0]        rmem_q [DEPTH];
    logic [PTR_W-1:0]   rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
    logic [FILL_W-1:0]  rcount_q, rcount_d;

    logic [15:0]        config_out_q, config_out_d;
    logic               config_out_valid_q, config_out_valid_d;
    logic               stats_shift_q, stats_shift_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               wpush, wpop, rpush, rpop;
    logic               cfg_ready, stat_room;

    assign host_wready      = (wcount_q != FILL_W'(DEPTH));
    assign host_rvalid      = (rcount_q != '0);
    assign host_rdata       = rmem_q[rrd_ptr_q];
    assign config_out       = config_out_q;
    assign config_out_valid = config_out_valid_q;
    assign stats_shift      = stats_shift_q;
    assign stats_out        = 16'h0000;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

    assign wpush     = host_wvalid & host_wready;
    assign rpop      = host_rvalid & host_rready;
    // Every shift cycle captures the word currently leaving the chain tail.
    assign rpush     = stats_shift_q;
    assign cfg_ready = (wcount_q >= FILL_W'(CFG_WORDS));
    assign stat_room = ((FILL_W'(DEPTH) - rcount_q) >= FILL_W'(STAT_WORDS));

    // Registered outputs are computed from the next state so that the first
    // config word / shift pulse is visible in the first cycle of the burst.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d            = state_q;
        cnt_d              = cnt_q;
        wpop               = 1'b0;
        error_d            = error_q;
        config_out_d       = '0;
        config_out_valid_d = 1'b0;
        stats_shift_d      = 1'b0;
        done_d             = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_config) begin
                    if (cfg_ready) begin
                        state_d            = CFG;
                        cnt_d              = '0;
                        wpop               = 1'b1;
                        config_out_d       = wmem_q[wrd_ptr_q];
                        config_out_valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (start_stats) begin
                    if (stat_room) begin
                        state_d       = STAT;
                        cnt_d         = '0;
                        stats_shift_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            CFG: begin
                if (cnt_q == CNT_W'(CFG_WORDS - 1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d              = cnt_q + CNT_W'(1);
                    wpop               = 1'b1;
                    config_out_d       = wmem_q[wrd_ptr_q];
                    config_out_valid_d = 1'b1;
                end
            end
            STAT: begin
                if (cnt_q == CNT_W'(STAT_WORDS - 1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    stats_shift_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_comb begin
        wwr_ptr_d = wwr_ptr_q + PTR_W'(wpush);
        wrd_ptr_d = wrd_ptr_q + PTR_W'(wpop);
        wcount_d  = wcount_q + FILL_W'(wpush) - FILL_W'(wpop);
        rwr_ptr_d = rwr_ptr_q + PTR_W'(rpush);
        rrd_ptr_d = rrd_ptr_q + PTR_W'(rpop);
        rcount_d  = rcount_q + FILL_W'(rpush) - FILL_W'(rpop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            wwr_ptr_q          <= '0;
            wrd_ptr_q          <= '0;
            wcount_q           <= '0;
            rwr_ptr_q          <= '0;
            rrd_ptr_q          <= '0;
            rcount_q           <= '0;
            config_out_q       <= '0;
            config_out_valid_q <= 1'b0;
            stats_shift_q      <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            wwr_ptr_q          <= wwr_ptr_d;
            wrd_ptr_q          <= wrd_ptr_d;
            wcount_q           <= wcount_d;
            rwr_ptr_q          <= rwr_ptr_d;
            rrd_ptr_q          <= rrd_ptr_d;
            rcount_q           <= rcount_d;
            config_out_q       <= config_out_d;
            config_out_valid_q <= config_out_valid_d;
            stats_shift_q      <= stats_shift_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            error_q            <= error_d;
        end
    end

    // NOTE: buffer storage is not reset; the cleared counts make stale contents unreachable.
    always_ff @(posedge clock) begin
        if (wpush) wmem_q[wwr_ptr_q] <= host_wdata;
        if (rpush) rmem_q[rwr_ptr_q] <= stats_in;
    end

endmodule

// File: tb/tb_tg_chain_master.sv
// Self-checking bench for tg_chain_master: a queue-based reference model feeds a
// scoreboard that a forked monitor drains whenever the DUT presents a word.
module tb_tg_chain_master;

    localparam int CFG_WORDS  = 16;
    localparam int STAT_WORDS = 8;
    localparam int LOG_DEPTH  = 5;
    localparam int DEPTH      = 1 << LOG_DEPTH;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] host_wdata = '0;
    logic        host_wvalid = 1'b0;
    logic        host_wready;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic        host_rready = 1'b0;
    logic        start_config = 1'b0;
    logic        start_stats = 1'b0;
    logic [15:0] config_out;
    logic        config_out_valid;
    logic        stats_shift;
    logic [15:0] stats_out;
    logic [15:0] stats_in;
    logic        busy;
    logic        done;
    logic        error;

    tg_chain_master #(
        .CFG_WORDS (CFG_WORDS),
        .STAT_WORDS(STAT_WORDS),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .host_wdata      (host_wdata),
        .host_wvalid     (host_wvalid),
        .host_wready     (host_wready),
        .host_rdata      (host_rdata),
        .host_rvalid     (host_rvalid),
        .host_rready     (host_rready),
        .start_config    (start_config),
        .start_stats     (start_stats),
        .config_out      (config_out),
        .config_out_valid(config_out_valid),
        .stats_shift     (stats_shift),
        .stats_out       (stats_out),
        .stats_in        (stats_in),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clock = ~clock;

    // Model of the stats chain ring: index STAT_WORDS-1 is the tail feeding the DUT.
    logic [15:0] chain      [STAT_WORDS];
    logic [15:0] chain_load [STAT_WORDS];
    logic        chain_load_req = 1'b0;
    assign stats_in = chain[STAT_WORDS-1];

    // Reference model state
    logic [15:0] wq[$];
    logic [15:0] cfg_exp[$];
    logic [15:0] rd_exp[$];
    bit          err_model = 1'b0;

    int checks = 0;
    int fails  = 0;
    int shift_cnt = 0;
    int done_cnt = 0;
    int cfg_valid_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        bit acc;
        acc = (wq.size() < DEPTH);
        check("host_wready", int'(host_wready), int'(acc));
        host_wvalid = 1'b1;
        host_wdata  = w;
        tick();
        host_wvalid = 1'b0;
        if (acc) wq.push_back(w);
    endtask

    task automatic load_chain(input bit rnd, input logic [15:0] base);
        for (int i = 0; i < STAT_WORDS; i++)
            chain_load[STAT_WORDS-1-i] = rnd ? 16'($urandom) : base + 16'(i);
        chain_load_req = 1'b1;
        tick();
        chain_load_req = 1'b0;
    endtask

    task automatic start_cfg(input bit with_stats, output bit acc);
        acc = (wq.size() >= CFG_WORDS);
        if (acc) begin
            for (int i = 0; i < CFG_WORDS; i++) cfg_exp.push_back(wq.pop_front());
        end else begin
            err_model = 1'b1;
        end
        start_config = 1'b1;
        start_stats  = with_stats;
        tick();
        start_config = 1'b0;
        start_stats  = 1'b0;
    endtask

    task automatic start_stat(output bit acc);
        acc = ((DEPTH - rd_exp.size()) >= STAT_WORDS);
        if (acc) begin
            for (int i = STAT_WORDS - 1; i >= 0; i--) rd_exp.push_back(chain_load[i]);
        end else begin
            err_model = 1'b1;
        end
        start_stats = 1'b1;
        tick();
        start_stats = 1'b0;
    endtask

    // Count the valid run; optionally poke both start inputs mid-burst.
    task automatic wait_cfg_burst(input int poke);
        int run;
        run = 0;
        while (config_out_valid && run < 40) begin
            if (run == poke) begin
                start_config = 1'b1;
                start_stats  = 1'b1;
            end
            tick();
            start_config = 1'b0;
            start_stats  = 1'b0;
            run++;
        end
        check("cfg_burst_len", run, CFG_WORDS);
        check("cfg_done", int'(done), 1);
        check("cfg_sb_empty", cfg_exp.size(), 0);
        tick();
        check("cfg_done_width", int'(done), 0);
        check("cfg_busy_after", int'(busy), 0);
    endtask

    task automatic wait_stat_burst();
        int run;
        run = 0;
        while (stats_shift && run < 40) begin
            tick();
            run++;
        end
        check("stat_burst_len", run, STAT_WORDS);
        check("stat_done", int'(done), 1);
        tick();
        check("stat_done_width", int'(done), 0);
        check("stat_busy_after", int'(busy), 0);
    endtask

    task automatic drain_reads(input bit rnd);
        int n;
        n = 0;
        while (rd_exp.size() > 0 && n < 400) begin
            host_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        host_rready = 1'b0;
        check("rd_sb_empty", rd_exp.size(), 0);
        check("rvalid_after_drain", int'(host_rvalid), 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        host_wvalid  = 1'b0;
        host_rready  = 1'b0;
        start_config = 1'b0;
        start_stats  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        wq.delete();
        cfg_exp.delete();
        rd_exp.delete();
        err_model = 1'b0;
    endtask

    initial begin
        bit acc;
        int snap;

        fork
            begin : monitor
                logic [15:0] exp_w;
                forever begin
                    @(negedge clock);
                    if (!reset) begin
                        if (stats_shift) shift_cnt++;
                        if (done) done_cnt++;
                        if (config_out_valid) begin
                            cfg_valid_cnt++;
                            if (cfg_exp.size() == 0) begin
                                check("cfg_unexpected_valid", int'(config_out_valid), 0);
                            end else begin
                                exp_w = cfg_exp.pop_front();
                                check("cfg_word", int'(config_out), int'(exp_w));
                            end
                        end
                        if (host_rvalid && host_rready) begin
                            if (rd_exp.size() == 0) begin
                                check("rd_unexpected", int'(host_rvalid), 0);
                            end else begin
                                exp_w = rd_exp.pop_front();
                                check("rd_word", int'(host_rdata), int'(exp_w));
                            end
                        end
                    end
                end
            end
            begin : chain_model
                forever begin
                    @(posedge clock);
                    if (chain_load_req) begin
                        for (int i = 0; i < STAT_WORDS; i++) chain[i] <= chain_load[i];
                    end else if (stats_shift) begin
                        for (int i = STAT_WORDS - 1; i > 0; i--) chain[i] <= chain[i-1];
                        chain[0] <= stats_out;
                    end
                end
            end
            begin : watchdog
                #200_000;
                $display("FAIL watchdog: timeout=1 required=0");
                $fatal(1, "bench timeout");
            end
        join_none

        // Reset state
        load_chain(1'b0, 16'h0000);
        do_reset();
        check("rst_wready", int'(host_wready), 1);
        check("rst_rvalid", int'(host_rvalid), 0);
        check("rst_config_out", int'(config_out), 0);
        check("rst_config_valid", int'(config_out_valid), 0);
        check("rst_stats_shift", int'(stats_shift), 0);
        check("rst_stats_out", int'(stats_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);

        // Directed config burst 0x1000..0x100F
        for (int i = 0; i < CFG_WORDS; i++) push_word(16'h1000 + 16'(i));
        start_cfg(1'b0, acc);
        wait_cfg_burst(-1);
        check("cfg1_wready", int'(host_wready), 1);
        check("cfg1_error", int'(error), int'(err_model));

        // Simultaneous start requests: config wins, stats dropped
        for (int i = 0; i < CFG_WORDS; i++) push_word(16'($urandom));
        snap = shift_cnt;
        start_cfg(1'b1, acc);
        wait_cfg_burst(-1);
        repeat (3) tick();
        check("simul_no_shift", shift_cnt, snap);
        check("simul_error", int'(error), int'(err_model));

        // Directed stats readout 0xA0..0xA7
        load_chain(1'b0, 16'h00A0);
        start_stat(acc);
        wait_stat_burst();
        drain_reads(1'b0);

        // Random stats readouts with a stalling host
        for (int k = 0; k < 2; k++) begin
            load_chain(1'b1, 16'h0000);
            start_stat(acc);
            wait_stat_burst();
            drain_reads(1'b1);
        end

        // Leftover words, pointer wrap, and starts ignored while busy
        for (int i = 0; i < CFG_WORDS + 4; i++) push_word(16'($urandom));
        snap = shift_cnt;
        start_cfg(1'b0, acc);
        wait_cfg_burst(3);
        check("busy_start_no_error", int'(error), int'(err_model));
        check("busy_start_no_shift", shift_cnt, snap);
        for (int i = 0; i < CFG_WORDS - 4; i++) push_word(16'($urandom));
        start_cfg(1'b0, acc);
        wait_cfg_burst(-1);

        // Read-buffer fill: 24 used leaves exactly STAT_WORDS free, then full
        for (int k = 0; k < DEPTH / STAT_WORDS; k++) begin
            load_chain(1'b1, 16'h0000);
            start_stat(acc);
            wait_stat_burst();
        end
        check("full_error_clear", int'(error), int'(err_model));
        check("full_rvalid", int'(host_rvalid), 1);
        load_chain(1'b1, 16'h0000);
        snap = shift_cnt;
        start_stat(acc);
        repeat (5) tick();
        check("ovf_no_shift", shift_cnt, snap);
        check("ovf_error", int'(error), int'(err_model));
        check("ovf_busy", int'(busy), 0);
        drain_reads(1'b1);
        check("ovf_error_sticky", int'(error), 1);

        // Underfill
        do_reset();
        check("post_reset_error", int'(error), 0);
        for (int i = 0; i < 5; i++) push_word(16'($urandom));
        snap = cfg_valid_cnt;
        start_cfg(1'b0, acc);
        check("under_error", int'(error), int'(err_model));
        repeat (10) tick();
        check("under_no_valid", cfg_valid_cnt, snap);
        check("under_error_held", int'(error), 1);
        check("under_busy", int'(busy), 0);
        for (int i = 0; i < CFG_WORDS - 5; i++) push_word(16'($urandom));
        start_cfg(1'b0, acc);
        wait_cfg_burst(-1);

        // Reset on the 6th valid cycle of a config burst
        load_chain(1'b1, 16'h0000);
        start_stat(acc);
        wait_stat_burst();
        for (int i = 0; i < CFG_WORDS; i++) push_word(16'($urandom));
        start_cfg(1'b0, acc);
        repeat (5) tick();
        check("midrst_valid_before", int'(config_out_valid), 1);
        snap  = done_cnt;
        reset = 1'b1;
        tick();
        check("midrst_valid", int'(config_out_valid), 0);
        check("midrst_wready", int'(host_wready), 1);
        check("midrst_rvalid", int'(host_rvalid), 0);
        check("midrst_shift", int'(stats_shift), 0);
        reset = 1'b0;
        wq.delete();
        cfg_exp.delete();
        rd_exp.delete();
        err_model = 1'b0;
        repeat (20) tick();
        check("midrst_no_done", done_cnt, snap);
        check("midrst_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
